// File: rtl/fir_pkg.sv
// Shared types and default constants for the folded FIR engine.
package fir_pkg;
    localparam int FIR_DATA_W = 32;
    localparam int FIR_COEF_W = 16;
    localparam int FIR_TAPS   = 10;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic signed [15:0] FIR_H_DEFAULT [FIR_TAPS] = '{
        16'sd129, 16'sd721, 16'sd592, 16'sd80, 16'sd81,
        16'sd78, -16'sd15, -16'sd93, 16'sd95, 16'sd127
    };

    // Taps beyond the built-in table default to zero.
    function automatic logic signed [15:0] fir_default_coef(input int k);
        logic signed [15:0] c;
        c = '0;
        for (int i = 0; i < FIR_TAPS; i++) begin
            if (k == i) c = FIR_H_DEFAULT[i];
        end
        return c;
    endfunction
endpackage

// File: rtl/fir_mac.sv
// Single multiply-accumulate unit: acc += trunc(sext(coef) * sample), wrapping mod 2^DATA_W.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] acc
);
    localparam int PROD_W = DATA_W + COEF_W;

    function automatic logic signed [DATA_W-1:0] trunc_prod(input logic signed [PROD_W-1:0] p);
        return p[DATA_W-1:0];
    endfunction

    logic signed [PROD_W-1:0] prod;

    assign prod = PROD_W'(coef) * PROD_W'(sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + trunc_prod(prod);
        end
    end
endmodule

// File: rtl/fir_fold_sequencer.sv
// Folded FIR: sequencer FSM, circular sample buffer, runtime coefficient table and one MAC.
module fir_fold_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int TAPS   = FIR_TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [DATA_W-1:0]        x_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [DATA_W-1:0]        y_data,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     coef_err,
    output logic                     busy
);
    localparam int PTR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS - 1);

    state_t state, state_nxt;

    logic [PTR_W-1:0]         wptr, newest, k, rd_idx;
    logic signed [DATA_W-1:0] sbuf [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] acc;
    logic [DATA_W-1:0]        y_hold;
    logic                     accept, last_tap, out_fire, coef_ok;

    assign accept   = x_valid && (state == IDLE);
    assign last_tap = (state == MAC) && (k == LAST);
    assign out_fire = (state == OUT) && y_ready;
    assign coef_ok  = (state == IDLE) && (int'(coef_addr) < TAPS);

    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        y_valid   = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                x_ready = 1'b1;
                if (x_valid) state_nxt = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (k == LAST) state_nxt = OUT;
            end
            OUT: begin
                busy    = 1'b1;
                y_valid = 1'b1;
                if (y_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tap k reads the sample k positions older than the newest one, wrapping around the ring.
    always_comb begin
        if (newest >= k) rd_idx = newest - k;
        else             rd_idx = newest + PTR_W'(TAPS) - k;
    end

    // y_data follows the live accumulator in OUT and otherwise shows the last delivered result.
    assign y_data = (state == OUT) ? acc : y_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            newest   <= '0;
            k        <= '0;
            coef_err <= 1'b0;
            y_hold   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                sbuf[i] <= '0;
                coef[i] <= COEF_W'(fir_default_coef(i));
            end
        end else begin
            state    <= state_nxt;
            coef_err <= coef_we && !coef_ok;
            if (accept) begin
                for (int i = 0; i < TAPS; i++) begin
                    if (wptr == PTR_W'(i)) sbuf[i] <= x_data;
                end
                newest <= wptr;
                wptr   <= (wptr == LAST) ? '0 : wptr + 1'b1;
                k      <= '0;
            end else if ((state == MAC) && !last_tap) begin
                k <= k + 1'b1;
            end
            if (out_fire) y_hold <= acc;
            if (coef_we && coef_ok) begin
                for (int i = 0; i < TAPS; i++) begin
                    if (coef_addr == 4'(i)) coef[i] <= coef_wdata;
                end
            end
        end
    end

    fir_mac #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == MAC),
        .coef  (coef[k]),
        .sample(sbuf[rd_idx]),
        .acc   (acc)
    );
endmodule

// File: tb/tb_fir_fold_sequencer.sv
// Directed-vector bench for the folded 10-tap FIR sequencer.
module tb_fir_fold_sequencer;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [31:0]        x_data = '0;
    logic               y_valid;
    logic               y_ready = 1'b0;
    logic [31:0]        y_data;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               coef_err;
    logic               busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;

    fir_fold_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_data    (y_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .coef_err  (coef_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        rst_n = 1'b0; x_valid = 1'b0; y_ready = 1'b0; coef_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] x);
        int n;
        n = 0;
        while (x_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (x_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL send_wait x_ready=%b required 1 within 50 cycles", x_ready);
        end
        x_valid = 1'b1; x_data = x;
        @(posedge clk); #1;
        acc_cyc = cyc;
        x_valid = 1'b0;
    endtask

    task automatic get_y(output logic [31:0] v, output bit timeout);
        int n;
        n = 0; v = '0; timeout = 1'b1; y_ready = 1'b1;
        while (timeout && n < 40) begin
            if (y_valid === 1'b1) begin
                v = y_data; timeout = 1'b0;
            end else begin
                @(posedge clk); #1; n++;
            end
        end
        if (!timeout) begin
            @(posedge clk); #1;
        end
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (x_ready !== 1'b1) begin miscompares++; $display("FAIL rst_x_ready got %b want 1", x_ready); end
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL rst_y_valid got %b want 0", y_valid); end
        vectors++; if (y_data !== 32'd0) begin miscompares++; $display("FAIL rst_y_data got %h want 0", y_data); end
        vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL rst_coef_err got %b want 0", coef_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    endtask

    task automatic test_impulse();
        logic [31:0] hexp [10];
        logic [31:0] v;
        bit to;
        int first_acc;
        hexp = '{32'd129, 32'd721, 32'd592, 32'd80, 32'd81, 32'd78,
                 32'hFFFFFFF1, 32'hFFFFFFA3, 32'd95, 32'd127};
        first_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 32'd1 : 32'd0);
            if (i == 0) first_acc = acc_cyc;
            if (i == 1) begin
                vectors++;
                if (acc_cyc - first_acc !== 12) begin
                    miscompares++;
                    $display("FAIL impulse_period got %0d cycles want 12", acc_cyc - first_acc);
                end
            end
            get_y(v, to);
            vectors++;
            if (to || v !== hexp[i]) begin
                miscompares++;
                $display("FAIL impulse_y%0d got %h (timeout=%0b) want %h", i, v, to, hexp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        send(32'd2);
        while (y_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            x_valid = 1'b1; x_data = 32'hDEAD_BEEF;
            vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL bp_y_valid c%0d got %b want 1", i, y_valid); end
            vectors++; if (y_data !== 32'd258) begin miscompares++; $display("FAIL bp_y_data c%0d got %h want %h", i, y_data, 32'd258); end
            vectors++; if (x_ready !== 1'b0) begin miscompares++; $display("FAIL bp_x_ready c%0d got %b want 0", i, x_ready); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy c%0d got %b want 1", i, busy); end
            @(posedge clk); #1;
        end
        x_valid = 1'b0; y_ready = 1'b1;
        @(posedge clk); #1;
        y_ready = 1'b0;
        vectors++; if (x_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_x_ready got %b want 1", x_ready); end
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_y_valid got %b want 0", y_valid); end
        vectors++; if (y_data !== 32'd258) begin miscompares++; $display("FAIL bp_hold_y_data got %h want %h", y_data, 32'd258); end
    endtask

    task automatic test_reprogram();
        logic [31:0] v;
        bit to;
        for (int i = 0; i < 10; i++) begin
            coef_we = 1'b1; coef_addr = 4'(i); coef_wdata = (i == 0) ? 16'sd2 : 16'sd0;
            @(posedge clk); #1;
            vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL prog_err%0d got %b want 0", i, coef_err); end
        end
        coef_we = 1'b1; coef_addr = 4'd12; coef_wdata = 16'sd55;
        @(posedge clk); #1;
        coef_we = 1'b0;
        vectors++; if (coef_err !== 1'b1) begin miscompares++; $display("FAIL badaddr_err got %b want 1", coef_err); end
        @(posedge clk); #1;
        vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL badaddr_pulse got %b want 0", coef_err); end
        send(32'd3);
        get_y(v, to);
        vectors++; if (to || v !== 32'd6) begin miscompares++; $display("FAIL prog_y got %h (timeout=%0b) want %h", v, to, 32'd6); end
        send(32'd5);
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'sd100;
        @(posedge clk); #1;
        coef_we = 1'b0;
        vectors++; if (coef_err !== 1'b1) begin miscompares++; $display("FAIL mac_write_err got %b want 1", coef_err); end
        @(posedge clk); #1;
        vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL mac_write_pulse got %b want 0", coef_err); end
        get_y(v, to);
        vectors++; if (to || v !== 32'd10) begin miscompares++; $display("FAIL mac_write_y got %h (timeout=%0b) want %h", v, to, 32'd10); end
        x_valid = 1'b1; x_data = 32'd3;
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'sd4;
        @(posedge clk); #1;
        x_valid = 1'b0; coef_we = 1'b0;
        vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL simul_err got %b want 0", coef_err); end
        get_y(v, to);
        vectors++; if (to || v !== 32'd12) begin miscompares++; $display("FAIL simul_y got %h (timeout=%0b) want %h", v, to, 32'd12); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        bit to;
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'sd4;
        @(posedge clk); #1;
        coef_we = 1'b0;
        send(32'h4000_0000);
        get_y(v, to);
        vectors++; if (to || v !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_pos got %h (timeout=%0b) want 00000000", v, to); end
        send(32'hFFFF_FFFF);
        get_y(v, to);
        vectors++; if (to || v !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_neg got %h (timeout=%0b) want fffffffc", v, to); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] v;
        bit to;
        send(32'd9);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_y_valid got %b want 0", y_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (x_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_x_ready got %b want 1", x_ready); end
        vectors++; if (y_data !== 32'd0) begin miscompares++; $display("FAIL midrst_y_data got %h want 0", y_data); end
        send(32'd1);
        get_y(v, to);
        vectors++; if (to || v !== 32'd129) begin miscompares++; $display("FAIL midrst_imp0 got %h (timeout=%0b) want %h", v, to, 32'd129); end
        send(32'd0);
        get_y(v, to);
        vectors++; if (to || v !== 32'd721) begin miscompares++; $display("FAIL midrst_imp1 got %h (timeout=%0b) want %h", v, to, 32'd721); end
    endtask

    task automatic test_stream();
        int hc [10];
        int hist [10];
        int expv;
        int n;
        logic [31:0] v;
        bit got;
        hc = '{129, 721, 592, 80, 81, 78, -15, -93, 95, 127};
        for (int i = 0; i < 10; i++) hist[i] = 0;
        do_reset();
        for (int s = 1; s <= 25; s++) begin
            for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = s;
            expv = 0;
            for (int i = 0; i < 10; i++) expv = expv + hc[i] * hist[i];
            send(32'(s));
            got = 1'b0; n = 0; v = '0;
            while (!got && n < 200) begin
                y_ready = 1'($urandom_range(0, 1));
                if (y_valid === 1'b1 && y_ready) begin
                    v = y_data; got = 1'b1;
                end
                @(posedge clk); #1; n++;
            end
            y_ready = 1'b0;
            vectors++;
            if (!got || v !== 32'(expv)) begin
                miscompares++;
                $display("FAIL stream_s%0d got %h (seen=%0b) want %h", s, v, got, 32'(expv));
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_reprogram();
        test_wrap();
        test_reset_midop();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
